// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Issues one operation at a time and returns the captured result with the issuer id.
module alu_share_ctrl #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_control,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_control,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [CTRL_W-1:0] alu_control,
  output logic [WIDTH-1:0]  alu_in1,
  output logic [WIDTH-1:0]  alu_in2,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              alu_zero
);

  // state | meaning
  // IDLE  | waiting for a request; ready offered to the granted requester
  // EXEC  | operand regs drive the ALU; result captured at end of cycle
  // RESP  | response held until the consumer takes it
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic              last;
  logic              grant0;
  logic              grant1;
  logic [CTRL_W-1:0] sel_control;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;

  function automatic logic code_supported(input logic [CTRL_W-1:0] code);
    return (code == CTRL_W'(0)) || (code == CTRL_W'(1)) || (code == CTRL_W'(2)) ||
           (code == CTRL_W'(6)) || (code == CTRL_W'(7)) || (code == CTRL_W'(12));
  endfunction

  // On contention the requester that was not served last wins.
  always_comb begin
    grant0      = req0_valid && (!req1_valid || last);
    grant1      = req1_valid && (!req0_valid || !last);
    req0_ready  = (state == IDLE) && grant0;
    req1_ready  = (state == IDLE) && grant1;
    sel_control = grant1 ? req1_control : req0_control;
    sel_a       = grant1 ? req1_a : req0_a;
    sel_b       = grant1 ? req1_b : req0_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_err     <= 1'b0;
      alu_control <= '0;
      alu_in1     <= '0;
      alu_in2     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            alu_control <= sel_control;
            alu_in1     <= sel_a;
            alu_in2     <= sel_b;
            rsp_id      <= grant1;
            rsp_err     <= !code_supported(sel_control);
            state       <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_out;
          rsp_zero   <= alu_zero;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            last      <= rsp_id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: vector table, corner-case sequences and randomized
// traffic checked against an arithmetic reference of the sharing rules.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_control, req1_control, alu_control;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, alu_zero;
  logic [31:0] rsp_result, alu_in1, alu_in2, alu_out;

  int checks = 0;
  int failures = 0;
  bit mlast;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_control(req0_control),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_control(req1_control),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_control(alu_control), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return (a < b) ? 32'd1 : 32'd0;
      4'd12:   return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  // Stand-in for the shared ALU.
  always_comb begin
    alu_out  = ref_alu(alu_control, alu_in1, alu_in2);
    alu_zero = (alu_out == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
  endtask

  // One complete transaction from IDLE; expectations are supplied by the caller.
  task automatic run_op(input bit v0, input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                        input bit v1, input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                        input bit eid, input logic [31:0] eres, input bit ezero, input bit eerr,
                        input int delay);
    logic [3:0]  ec;
    logic [31:0] ea, eb;
    ec = eid ? c1 : c0;
    ea = eid ? a1 : a0;
    eb = eid ? b1 : b0;
    req0_valid = v0; req0_control = c0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_control = c1; req1_a = a1; req1_b = b1;
    rsp_ready = 0;
    #1;
    chk("req0_ready_grant", 32'(req0_ready), 32'(eid == 1'b0));
    chk("req1_ready_grant", 32'(req1_ready), 32'(eid == 1'b1));
    step();
    req0_valid = 0; req1_valid = 0;
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_alu_control", 32'(alu_control), 32'(ec));
    chk("exec_alu_in1", alu_in1, ea);
    chk("exec_alu_in2", alu_in2, eb);
    step();
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_id", 32'(rsp_id), 32'(eid));
    chk("rsp_result", rsp_result, eres);
    chk("rsp_zero", 32'(rsp_zero), 32'(ezero));
    chk("rsp_err", 32'(rsp_err), 32'(eerr));
    for (int i = 0; i < delay; i++) begin
      step();
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_result", rsp_result, eres);
    end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("rsp_done", 32'(rsp_valid), 32'd0);
    mlast = eid;
  endtask

  typedef struct {
    bit v0; logic [3:0] c0; logic [31:0] a0, b0;
    bit v1; logic [3:0] c1; logic [31:0] a1, b1;
    bit eid; logic [31:0] eres; bit ezero; bit eerr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 4'd6, 32'd9, 32'd9, 1'b1, 4'd1, 32'hF0, 32'h0F, 1'b0, 32'd0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 4'd6, 32'd9, 32'd9, 1'b1, 4'd1, 32'hF0, 32'h0F, 1'b1, 32'hFF, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 4'd2, 32'd1, 32'd1, 1'b1, 4'd0, 32'hFF, 32'h0F, 1'b0, 32'd2, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 4'd2, 32'd1, 32'd1, 1'b1, 4'd0, 32'hFF, 32'h0F, 1'b1, 32'h0F, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 4'd2, 32'd5, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd12, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd7, 32'd3, 32'd5, 1'b1, 32'd1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd7, 32'hFFFFFFFF, 32'd1, 1'b1, 32'd0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 4'd3, 32'd1, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 4'd12, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd6, 32'h10, 32'h20, 1'b1, 32'hFFFFFFF0, 1'b0, 1'b0};

    idle_inputs();
    req0_control = 0; req0_a = 0; req0_b = 0;
    req1_control = 0; req1_a = 0; req1_b = 0;
    rst_n = 0;
    #1;
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_alu_control", 32'(alu_control), 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_alu_in2", alu_in2, 32'd0);
    step(); step();
    rst_n = 1;
    mlast = 1;
    step();

    // Stray rsp_ready while idle must not produce anything.
    rsp_ready = 1;
    step(); step();
    chk("idle_rsp_ready_ignored", 32'(rsp_valid), 32'd0);
    rsp_ready = 0;

    foreach (vecs[i])
      run_op(vecs[i].v0, vecs[i].c0, vecs[i].a0, vecs[i].b0,
             vecs[i].v1, vecs[i].c1, vecs[i].a1, vecs[i].b1,
             vecs[i].eid, vecs[i].eres, vecs[i].ezero, vecs[i].eerr, 0);

    // Backpressure: response held 5 cycles while req0 keeps asking.
    req0_valid = 1; req0_control = 4'd2; req0_a = 32'd1; req0_b = 32'd2;
    #1;
    chk("bp_first_ready", 32'(req0_ready), 32'd1);
    step();
    req0_control = 4'd1; req0_a = 32'h3; req0_b = 32'h4;
    chk("bp_exec_ready", 32'(req0_ready), 32'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_result", rsp_result, 32'd3);
      chk("bp_req0_ready", 32'(req0_ready), 32'd0);
      step();
    end
    rsp_ready = 1;
    #1;
    chk("bp_ready_at_handshake", 32'(req0_ready), 32'd0);
    step();
    rsp_ready = 0;
    chk("bp_after_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp_after_ready", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 0;
    step();
    chk("bp_second_valid", 32'(rsp_valid), 32'd1);
    chk("bp_second_result", rsp_result, 32'd7);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    mlast = 0;

    // Reset asserted mid-EXEC discards the operation and restores req0 priority.
    req0_valid = 1; req0_control = 4'd2; req0_a = 32'h100; req0_b = 32'h23;
    step();
    req0_valid = 0;
    chk("rx_in_exec", 32'(alu_in1), 32'h100);
    rst_n = 0;
    #1;
    chk("rx_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rx_rsp_result", rsp_result, 32'd0);
    chk("rx_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("rx_alu_control", 32'(alu_control), 32'd0);
    chk("rx_alu_in1", alu_in1, 32'd0);
    chk("rx_alu_in2", alu_in2, 32'd0);
    step(); step();
    chk("rx_no_response", 32'(rsp_valid), 32'd0);
    rst_n = 1;
    mlast = 1;
    step();
    chk("rx_post_release", 32'(rsp_valid), 32'd0);
    run_op(1'b1, 4'd0, 32'hC, 32'hA, 1'b1, 4'd2, 32'd1, 32'd1, 1'b0, 32'd8, 1'b0, 1'b0, 0);

    // Randomized traffic against the arbitration/ALU reference.
    for (int n = 0; n < 60; n++) begin
      bit v0, v1, eid;
      logic [3:0] c0, c1, codes[8];
      logic [31:0] a0, b0, a1, b1, eres;
      codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd15};
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1;
      c0 = codes[$urandom_range(0, 7)];
      c1 = codes[$urandom_range(0, 7)];
      a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
      a1 = $urandom; b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
      eid = (v0 && v1) ? !mlast : v1;
      eres = eid ? ref_alu(c1, a1, b1) : ref_alu(c0, a0, b0);
      run_op(v0, c0, a0, b0, v1, c1, a1, b1, eid, eres, eres == 32'd0,
             !((eid ? c1 : c0) inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12}),
             int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and arbiter sharing the single combinational ALU between two requesters (e.g. main datapath and address/branch unit). Accepts one operation at a time via valid/ready, round-robin between requesters, drives the ALU control/operand inputs from registered operands, captures result and zero flag, and returns them on a response handshake tagged with the requester ID. Also flags control codes the ALU does not implement.

## Interface
- WIDTH, 32, operand/result width; matches ALU data width
- CTRL_W, 4, ALU control code width

- Clock  in  1  single clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Req0_Valid  in  1  requester 0 has an operation
- Req0_Ready  out  1  requester 0 operation accepted this cycle
- Req0_Control  in  CTRL_W  ALU code (0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT unsigned, 12 NOR)
- Req0_A, Req0_B  in  WIDTH  operands
- Req1_Valid / Req1_Ready / Req1_Control / Req1_A / Req1_B  same, requester 1
- Rsp_Valid  out  1  result available
- Rsp_Ready  in  1  consumer takes result
- Rsp_Id  out  1  requester that issued the operation
- Rsp_Result  out  WIDTH  captured ALU output
- Rsp_Zero  out  1  captured ALU zero flag
- Rsp_Err  out  1  control code not in {0,1,2,6,7,12}
- AluControl  out  CTRL_W  to ALU Control
- AluIn1, AluIn2  out  WIDTH  to ALU Input1/Input2
- AluOut  in  WIDTH  from ALU Out
- AluZero  in  1  from ALU Zero

## Operation
- States: IDLE, EXEC, RESP. Reset -> IDLE.
- Round-robin pointer Last (1 bit), reset 1 (requester 0 wins first contest).
- IDLE: grant = only valid requester; if both valid, requester != Last. ReqX_Ready = (state==IDLE) && grant==X (combinational; both 0 if no valid). On handshake: latch Control, A, B into operand regs, Id = X, Err = code unsupported; -> EXEC.
- EXEC: AluControl/AluIn1/AluIn2 always driven from operand regs (also outside EXEC; stable). End of cycle: Rsp_Result <= AluOut, Rsp_Zero <= AluZero; -> RESP.
- RESP: Rsp_Valid = 1; Rsp_Id/Result/Zero/Err held stable until Rsp_Ready. On Rsp_Valid && Rsp_Ready: Last <= Rsp_Id; -> IDLE.
- No request accepted outside IDLE; one operation in flight max.
- Unsupported code still executed; ALU yields 0, so Result 0, Zero 1, Err 1.
- Controller performs no arithmetic; all widths pass through unchanged.

## Timing
- Reset values: Req0_Ready 0, Req1_Ready 0, Rsp_Valid 0, Rsp_Id 0, Rsp_Result 0, Rsp_Zero 0, Rsp_Err 0, AluControl 0, AluIn1 0, AluIn2 0; Last 1.
- Accept at edge T -> EXEC cycle T+1 -> Rsp_Valid high from T+2.
- Min issue interval 3 cycles (response consumed same cycle it appears); next accept earliest the cycle after the response handshake.
- Rsp_Ready low: stay in RESP indefinitely, outputs stable, both Ready 0.
- Requester dropping Valid before handshake: no effect, nothing latched.
- Reset_n low in any state: immediate return to reset values, in-flight op discarded, no response issued; after release, IDLE with Req0 priority.
- Rsp_Ready high with Rsp_Valid low: ignored.

## Test plan
- Req0 ADD A=5 B=7, Rsp_Ready=1 -> Req0_Ready at T, Rsp_Valid at T+2, Result 12, Zero 0, Id 0, Err 0.
- Both valid: Req0 SUB 9-9, Req1 OR 0xF0|0x0F -> first Id 0 Result 0 Zero 1; then Id 1 Result 0xFF; both again -> Id 0 then Id 1 alternate.
- Req1 SLT A=3 B=5 -> Result 1; then A=0xFFFFFFFF B=1 -> Result 0, Zero 1 (unsigned compare).
- Rsp_Ready low 5 cycles with Req0 valid -> Rsp_Valid/Result stable, Req0_Ready 0 throughout; accept only after response handshake.
- Req0 code 3 A=1 B=1 -> Result 0, Zero 1, Err 1; next valid op (NOR 0,0) -> 0xFFFFFFFF, Err 0.
- Reset_n low during EXEC -> all outputs 0 immediately, no Rsp_Valid; after release, Req0 AND 0xC&0xA -> Result 8 with normal latency.
